// File: rtl/rr_arb_4to1.sv
// Four-requester round-robin arbiter with grant hold, hold-limit timeout and
// zero-bubble handoff; drives the select of the downstream 4:1 mux.
module rr_arb_4to1 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel,
  output logic       o_sel_valid,
  output logic       o_timeout
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;

  logic [1:0] w_base;
  logic [1:0] w_cand;
  logic [1:0] w_win_idx;
  logic       w_win_any;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_to;
  logic       w_release;
  logic       w_to_only;

  // On release the search starts just past the outgoing owner, so it ranks last.
  assign w_base = (r_state == S_GRANT) ? (o_sel + 2'd1) : r_ptr;

  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = w_base;
    w_cand    = w_base;
    for (int k = 3; k >= 0; k--) begin
      w_cand = w_base + 2'(k);
      if (i_req[w_cand]) begin
        w_win_any = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  assign w_rel_done = i_done;
  assign w_rel_drop = ~i_req[o_sel];
  assign w_rel_to   = (r_cnt == HOLD_LAST);
  assign w_release  = (r_state == S_GRANT) && (w_rel_done || w_rel_drop || w_rel_to);
  assign w_to_only  = w_rel_to && !w_rel_done && !w_rel_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= 8'd0;
      o_grant     <= 4'b0000;
      o_sel       <= 2'd0;
      o_sel_valid <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_any) begin
            r_state     <= S_GRANT;
            o_grant     <= 4'b0001 << w_win_idx;
            o_sel       <= w_win_idx;
            o_sel_valid <= 1'b1;
            r_cnt       <= 8'd0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_ptr     <= o_sel + 2'd1;
            o_timeout <= w_to_only;
            if (w_win_any) begin
              o_grant <= 4'b0001 << w_win_idx;
              o_sel   <= w_win_idx;
              r_cnt   <= 8'd0;
            end else begin
              // sel keeps its last value so the downstream mux does not glitch
              r_state     <= S_IDLE;
              o_grant     <= 4'b0000;
              o_sel_valid <= 1'b0;
            end
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Scoreboard bench for rr_arb_4to1: expected {grant,sel,sel_valid,timeout}
// is queued when a cycle is driven and checked after that cycle's edge.
module tb_rr_arb_4to1;

  logic       clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic       i_done;
  logic [3:0] o_grant;
  logic [1:0] o_sel;
  logic       o_sel_valid;
  logic       o_timeout;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] sb_q[$];

  rr_arb_4to1 #(.MAX_HOLD(16)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_done     (i_done),
    .o_grant    (o_grant),
    .o_sel      (o_sel),
    .o_sel_valid(o_sel_valid),
    .o_timeout  (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f_exp(input logic [3:0] g, input logic [1:0] s,
                                       input logic v, input logic t);
    return {g, s, v, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] req, input logic done,
                      input logic [7:0] exp);
    sb_q.push_back(exp);
    i_req  = req;
    i_done = done;
    @(posedge clk);
    #1;
    chk(tag, {o_grant, o_sel, o_sel_valid, o_timeout}, sb_q.pop_front());
  endtask

  initial begin
    i_rst  = 1'b1;
    i_req  = 4'b0000;
    i_done = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 4'b1111, 1'b1, f_exp(4'b0000, 2'd0, 1'b0, 1'b0));
    i_rst = 1'b0;

    // first grant, then reset mid-grant
    step("first_grant", 4'b0001, 1'b0, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));
    i_rst = 1'b1;
    step("rst_mid", 4'b0001, 1'b0, f_exp(4'b0000, 2'd0, 1'b0, 1'b0));
    i_rst = 1'b0;

    // rotation with done every cycle
    step("rot0", 4'b1111, 1'b0, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));
    step("rot1", 4'b1111, 1'b1, f_exp(4'b0010, 2'd1, 1'b1, 1'b0));
    step("rot2", 4'b1111, 1'b1, f_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    step("rot3", 4'b1111, 1'b1, f_exp(4'b1000, 2'd3, 1'b1, 1'b0));
    step("rot4", 4'b1111, 1'b1, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));

    // request drop
    step("drop_g2", 4'b0100, 1'b1, f_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    step("drop_g3", 4'b1001, 1'b0, f_exp(4'b1000, 2'd3, 1'b1, 1'b0));
    chk("drop_ptr", 32'(dut.r_ptr), 32'd3);
    step("drop_g0", 4'b0001, 1'b1, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));

    // idle hold: sel keeps last value, pointer wraps past source 1
    step("idle0", 4'b0000, 1'b1, f_exp(4'b0000, 2'd0, 1'b0, 1'b0));
    step("idle_g1", 4'b0010, 1'b0, f_exp(4'b0010, 2'd1, 1'b1, 1'b0));
    step("idle1", 4'b0000, 1'b1, f_exp(4'b0000, 2'd1, 1'b0, 1'b0));
    step("idle1b", 4'b0000, 1'b0, f_exp(4'b0000, 2'd1, 1'b0, 1'b0));
    step("idle_wrap", 4'b0011, 1'b0, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));

    // timeout: sole requester 2 held for two full hold windows
    step("to_g2", 4'b0100, 1'b0, f_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    for (int w = 0; w < 2; w++) begin
      for (int c = 1; c <= 16; c++)
        step("to_hold", 4'b0100, 1'b0, f_exp(4'b0100, 2'd2, 1'b1, (c == 16)));
    end

    // timeout with a second requester: 2 -> 1 -> 2
    for (int c = 1; c <= 16; c++)
      step("to_mv1", 4'b0110, 1'b0,
           (c == 16) ? f_exp(4'b0010, 2'd1, 1'b1, 1'b1) : f_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    for (int c = 1; c <= 16; c++)
      step("to_mv2", 4'b0110, 1'b0,
           (c == 16) ? f_exp(4'b0100, 2'd2, 1'b1, 1'b1) : f_exp(4'b0010, 2'd1, 1'b1, 1'b0));

    // done coinciding with the hold limit is not a timeout
    for (int c = 1; c <= 15; c++)
      step("dto_hold", 4'b0101, 1'b0, f_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    step("dto_rel", 4'b0101, 1'b1, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));
    step("dto_after", 4'b0001, 1'b0, f_exp(4'b0001, 2'd0, 1'b1, 1'b0));

    // reset overrides done/req activity
    i_rst = 1'b1;
    step("rst_final", 4'b1111, 1'b1, f_exp(4'b0000, 2'd0, 1'b0, 1'b0));
    chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
    i_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_4to1.md
# rr_arb_4to1

Four-requester round-robin arbiter with grant hold and timeout, sitting directly upstream of `mux_4to1` in the catalog. It decides which of four sources owns the shared path and drives the 2-bit select of the downstream 4:1 multiplexer. A grant is held until the owner signals done, drops its request, or exceeds a hold limit. Priority then rotates so that no requester starves.

## Interface
- `MAX_HOLD`, default 16, maximum cycles a grant may be held before forced release; legal range 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  4  request per source; bit i = source i.
- `done`  in  1  current owner releases the grant this cycle; ignored while `sel_valid`=0.
- `grant`  out  4  one-hot registered grant; all zero when idle.
- `sel`  out  2  binary index of granted source; feeds `mux_4to1` select.
- `sel_valid`  out  1  high while a grant is active; `sel` is meaningful only when high.
- `timeout`  out  1  one-cycle pulse on the cycle after a forced release.

## Operation
- Internal state:
  - FSM {IDLE, GRANT}.
  - Priority pointer `ptr[1:0]`.
  - Hold counter `cnt`, 8 bits, saturating, compared against `MAX_HOLD-1`.
- Priority search scans `ptr, ptr+1, ptr+2, ptr+3` (mod 4). The first set `req` bit wins.
- IDLE:
  - `grant`=0, `sel_valid`=0.
  - If `req`≠0, go to GRANT with the winner. `grant` = one-hot(winner), `sel` = winner, `cnt`=0.
  - Otherwise stay in IDLE.
- GRANT: each cycle `cnt` increments. A release condition exists when any of the following holds (checked in this order for reporting; any one releases):
  - (a) `done`=1.
  - (b) `req[sel]`=0.
  - (c) `cnt`==`MAX_HOLD-1`.
- On release:
  - `ptr` <= `sel`+1 (mod 4).
  - Re-arbitrate in the same cycle using the updated pointer over the current `req`. The releasing source is therefore lowest priority. It wins again only if it is the sole requester with `req` still high.
  - If a winner exists, stay in GRANT with the new grant and `cnt`=0 (no bubble).
  - If there is no winner, go to IDLE.
- `timeout` is set for one cycle only when release occurs by (c) alone. If (a) or (b) also holds that cycle, the release is not a timeout.
- Without a release, `grant`, `sel` and `ptr` are held unchanged regardless of other `req` activity.
- `sel` holds its last value in IDLE, since the downstream mux must not glitch. Consumers gate on `sel_valid`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `grant`=0000, `sel`=00, `sel_valid`=0, `timeout`=0. Internal state resets to FSM=IDLE, `ptr`=0, `cnt`=0.
- Reset mid-grant: outputs take their reset values after the rising edge where `rst`=1, regardless of `req`/`done`. Reset has priority over every other condition.
- Grant latency: a `req` sampled at edge N produces `grant`/`sel_valid` visible after edge N, i.e. one cycle.
- Release latency: `done` sampled at edge N changes `grant` after edge N. The new owner is visible in the same update (zero-bubble handoff).
- Maximum continuous ownership is exactly `MAX_HOLD` cycles of `sel_valid`=1 for one source. With `MAX_HOLD`=1, every grant lasts one cycle.
- `req` may change on any cycle. Requests arriving while a grant is held are served only at the next release.
- Starvation bound: with all four requesting continuously, any requester waits at most 3×`MAX_HOLD` cycles.

## Test plan
- Reset then `req`=0001, `done`=0: after one edge `grant`=0001, `sel`=0, `sel_valid`=1. Assert `rst` for one cycle: next edge gives `grant`=0000, `sel_valid`=0, `timeout`=0.
- Rotation: `req`=1111 held, pulse `done` each cycle. Grants follow 0001, 0010, 0100, 1000, 0001 with `sel` 0,1,2,3,0, no idle cycle between them.
- Request drop: grant on source 2, then `req` goes 0100 to 1001. Next edge `grant`=1000, `sel`=3, `ptr`=3. Then `req`=0001 with `done` gives `grant`=0001.
- Timeout (`MAX_HOLD`=16): `req`=0100, `done`=0 held. `sel_valid` stays high with `grant`=0100 throughout. `timeout` pulses once every 16 cycles. With `req`=0110, the grant moves to 0010 after 16 cycles with one `timeout` pulse, and the next grant goes to 0100.
- Simultaneous `done` and timeout on cycle `MAX_HOLD`-1: release occurs, `timeout` stays 0. Pending request 0001 gets `grant`=0001 next edge.
- Idle hold: grant source 1, `done` with `req`=0000. `grant`=0000, `sel_valid`=0, and `sel` stays 1 while idle. New `req`=0011 grants source 0 (pointer wrapped past 1).
